fetch_sequencer: RTL

Controller for the operand fetch unit. It presets the fetch unit's data pointers and drives its 3-bit control word. It reads each operand pair from data memory through a req/ack port and hands the pair to the execution stage over a valid/ready handshake. It sits between the issue logic (start, pair count, mode) and the fetch unit plus data-memory read port, and sequences one job of N operand pairs per start.

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Operand fetch sequencer: presets the fetch unit, reads each operand pair through a
// req/ack memory port and presents it to the execution stage over valid/ready.
module fetch_sequencer #(
    parameter int addrsize = 5,
    parameter int datasize = 8,
    parameter int cntsize  = 4
) (
    input  logic                clk,
    input  logic                preset_n,
    input  logic                start,
    input  logic [cntsize-1:0]  num_pairs,
    input  logic                chain,
    input  logic                abort,
    output logic                fu_preset,
    output logic [2:0]          fu_ctrl,
    input  logic                fu_ready,
    input  logic [addrsize-1:0] fu_addr0,
    input  logic [addrsize-1:0] fu_addr1,
    output logic                mem_req,
    output logic [addrsize-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [datasize-1:0] mem_rdata,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [datasize-1:0] op0,
    output logic [datasize-1:0] op1,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    typedef enum logic [2:0] {IDLE, PRE, WAIT, RD0, RD1, PRES, ADV, DONE} state_t;

    state_t             state;
    state_t             nxt;
    logic [cntsize-1:0] remaining;
    logic               chain_q;
    logic               abort_pend;
    logic               stop;
    logic               ab_exit;

    assign stop = abort | abort_pend;

    always_comb begin
        nxt     = state;
        ab_exit = 1'b0;
        case (state)
            IDLE: if (start) nxt = (num_pairs == '0) ? DONE : PRE;
            PRE:  nxt = WAIT;
            WAIT: begin
                // A wrapped pointer (fu_ready low) parks here until abort or reset.
                if (stop) begin
                    nxt     = DONE;
                    ab_exit = 1'b1;
                end else if (fu_ready) begin
                    nxt = RD0;
                end
            end
            RD0: if (mem_ack) begin
                nxt     = stop ? DONE : RD1;
                ab_exit = stop;
            end
            RD1: if (mem_ack) begin
                nxt     = stop ? DONE : PRES;
                ab_exit = stop;
            end
            PRES: begin
                if (stop) begin
                    nxt     = DONE;
                    ab_exit = 1'b1;
                end else if (op_ready) begin
                    nxt = (remaining == '0) ? DONE : ADV;
                end
            end
            ADV:     nxt = WAIT;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always match the current state.
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state      <= IDLE;
            fu_preset  <= 1'b0;
            fu_ctrl    <= 3'b000;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            op_valid   <= 1'b0;
            op0        <= '0;
            op1        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            remaining  <= '0;
            chain_q    <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state     <= nxt;
            fu_preset <= (nxt == PRE);
            fu_ctrl   <= (nxt == ADV) ? (chain_q ? 3'b100 : 3'b111) : 3'b000;
            mem_req   <= (nxt == RD0) || (nxt == RD1);
            op_valid  <= (nxt == PRES);
            busy      <= (nxt != IDLE);
            done      <= (nxt == DONE);
            aborted   <= ab_exit;

            if (state == IDLE && start) begin
                remaining <= num_pairs;
                chain_q   <= chain;
            end

            if (state == WAIT && nxt == RD0) mem_addr <= fu_addr0;
            if (state == RD0 && nxt == RD1)  mem_addr <= fu_addr1;

            if (state == RD0 && mem_ack) op0 <= mem_rdata;
            if (state == RD1 && mem_ack) begin
                op1       <= mem_rdata;
                remaining <= remaining - 1'b1;
            end

            // Abort in PRE/ADV takes effect one cycle later; in a read it waits for the ack.
            if (state == DONE || state == IDLE)
                abort_pend <= 1'b0;
            else if (abort && (state == PRE || state == ADV || state == RD0 || state == RD1))
                abort_pend <= 1'b1;
        end
    end

endmodule
